// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch controller
// and its fetch buffer.
// Contents: FSM state enum, PC step, instruction width, buffer entry type.
package fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

   // One fetch buffer slot: the instruction word tagged with its address.
   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: shift-register FIFO for fetched entries; slot 0 is always the head.
// Ports: clk, rst_n, push_i/push_dat_i (enqueue), pop_i (dequeue head), flush_i
//        (empty the buffer, wins over push), full_o, empty_o, head_o.
// Latency: a pushed entry is visible at head_o the cycle after the push edge;
//          head_o comes straight from a flop, so the consumer sees registered data.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  fetch_entry_t push_dat_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         full_o,
   output logic         empty_o,
   output fetch_entry_t head_o
);

   fetch_entry_t     ent_q [DEPTH];
   fetch_entry_t     ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] vld_d;
   logic             placed;

   always_comb begin
      ent_d  = ent_q;
      vld_d  = vld_q;
      placed = 1'b0;
      // Pop first so a push into a full buffer lands in the freed slot.
      if (pop_i) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = ent_q[i + 1];
            vld_d[i] = vld_q[i + 1];
         end
         vld_d[DEPTH-1] = 1'b0;
      end
      if (push_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!vld_d[i] && !placed) begin
               ent_d[i] = push_dat_i;
               vld_d[i] = 1'b1;
               placed   = 1'b1;
            end
         end
      end
      if (flush_i) begin
         vld_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

   assign full_o  = vld_q[DEPTH-1];
   assign empty_o = !vld_q[0];
   assign head_o  = ent_q[0];

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer; owns the PC, fetches one word per cycle
// from a combinational instruction memory into a small buffer for decode.
// Ports: clk, rst_n; imem_addr/imem_instr (memory); out_valid/out_ready/out_instr/
//        out_pc (decode handshake); redirect_valid/redirect_pc; halt_req; halted; fault.
// Build option: FETCH_MISALIGN_TRAP_EN makes misaligned redirects trap into FAULT;
//        without it the low two target bits are dropped and fault is tied 0.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [31:0]        out_pc,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               halt_req,
   output logic               halted,
   output logic               fault
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic         halted_q;
   logic         fifo_full;
   logic         fifo_empty;
   logic         pop;
   logic         push;
   logic         redir;
   logic         misalign;
   logic [31:0]  target;
   fetch_entry_t push_dat;
   fetch_entry_t head;

   // FAULT ignores redirects; only reset leaves it.
   assign redir = redirect_valid && (state_q != ST_FAULT);

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   assign misalign = redir && (redirect_pc[1:0] != 2'b00);
   assign target   = redirect_pc;
   assign fault    = fault_q;
`else
   assign misalign = 1'b0;
   assign target   = redirect_pc & ~32'd3;
   assign fault    = 1'b0;
`endif

   assign pop  = !fifo_empty && out_ready;
   // A same-cycle pop frees a slot, so a full buffer can still accept the fetch.
   assign push = (state_q == ST_RUN) && !redirect_valid && (!fifo_full || pop);

   assign push_dat.pc    = pc_q;
   assign push_dat.instr = imem_instr;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (push),
      .push_dat_i (push_dat),
      .pop_i      (pop),
      .flush_i    (redir),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_o     (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q  <= 1'b0;
`endif
      end else if (redir) begin
         pc_q <= target;
         if (misalign) begin
            state_q  <= ST_FAULT;
            halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q  <= 1'b1;
`endif
         end else if (halt_req) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
         end else begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
         end
      end else begin
         if (push) begin
            pc_q <= pc_q + PC_STEP;
         end
         // The halting cycle's own fetch still goes through (push above).
         if ((state_q == ST_RUN) && halt_req) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
         end
      end
   end

   assign imem_addr = pc_q;
   assign out_valid = !fifo_empty;
   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt_req = 1'b0;
   logic        halted;
   logic        fault;

   int errors = 0;
   int checks = 0;

   // Reference model: queue of {pc, instr}, PC and two status flags.
   logic [63:0] m_q[$];
   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_fault;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] + a[7:0] + 16'h1234};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   fetch_ctrl #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .halted         (halted),
      .fault          (fault)
   );

   task automatic model_reset();
      m_q.delete();
      m_pc     = 32'h0;
      m_halted = 1'b0;
      m_fault  = 1'b0;
   endtask

   // Applies one clock edge to the model using the currently driven inputs.
   task automatic model_edge();
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_fault) begin
      end else if (redirect_valid) begin
         m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            m_fault  = 1'b1;
            m_halted = 1'b0;
            m_pc     = redirect_pc;
         end else begin
            m_pc     = redirect_pc;
            m_halted = halt_req;
         end
`else
         m_pc     = {redirect_pc[31:2], 2'b00};
         m_halted = halt_req;
`endif
      end else if (!m_halted) begin
         if (m_q.size() < DEPTH) begin
            m_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
         end
         if (halt_req) m_halted = 1'b1;
      end
   endtask

   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic hr, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt_req       = hr;
      out_ready      = rdy;
      @(posedge clk);
      model_edge();
      #1;
      redirect_valid = 1'b0;
      halt_req       = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      halt_req = 1'b0;
      out_ready = 1'b0;
      #2;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      model_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_status got=%b%b exp=00", halted, fault); end
      checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL rst_out got=%h/%h exp=0/0", out_pc, out_instr); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'h0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== mem_word(32'(4 * i))) begin
            errors++;
            $display("FAIL stream_%0d got v=%b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                     i, out_valid, out_pc, out_instr, 32'(4 * i), mem_word(32'(4 * i)));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr got=%h exp=00000008", imem_addr); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b0, 1'b1);
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== mem_word(exp_pc[i])) begin
            errors++;
            $display("FAIL bp_drain_%0d got pc=%h exp pc=%h", i, out_pc, exp_pc[i]);
         end
      end
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL redir_pre got=%h exp=00000008", out_pc); end
      cycle(1'b1, 32'h40, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_bubble got v=%b addr=%h exp v=0 addr=00000040", out_valid, imem_addr); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL redir_t0 got v=%b pc=%h exp v=1 pc=00000040", out_valid, out_pc); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44) begin errors++; $display("FAIL redir_t1 got v=%b pc=%h exp v=1 pc=00000044", out_valid, out_pc); end
   endtask

   task automatic test_halt();
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_rise got=%b exp=1", halted); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h8 || halted !== 1'b1) begin
         errors++; $display("FAIL halt_drain got v=%b addr=%h h=%b exp v=0 addr=00000008 h=1", out_valid, imem_addr, halted);
      end
      cycle(1'b1, 32'h100, 1'b0, 1'b1);
      checks++; if (halted !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL halt_resume got h=%b v=%b exp h=0 v=0", halted, out_valid); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL halt_target got v=%b pc=%h exp v=1 pc=00000100", out_valid, out_pc); end
   endtask

   task automatic test_wrap();
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last got=%h exp=fffffffc", out_pc); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
   endtask

   task automatic test_misalign();
      cycle(1'b1, 32'h42, 1'b0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++; if (fault !== 1'b1 || imem_addr !== 32'h42) begin errors++; $display("FAIL mis_fault got f=%b addr=%h exp f=1 addr=00000042", fault, imem_addr); end
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL mis_stuck got v=%b f=%b exp v=0 f=1", out_valid, fault); end
      rst_n = 1'b0;
      #2;
      model_reset();
      checks++; if (fault !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mis_clear got f=%b addr=%h exp f=0 addr=0", fault, imem_addr); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
`else
      checks++; if (fault !== 1'b0 || imem_addr !== 32'h40) begin errors++; $display("FAIL mis_align got f=%b addr=%h exp f=0 addr=00000040", fault, imem_addr); end
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL mis_pc got v=%b pc=%h exp v=1 pc=00000040", out_valid, out_pc); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      model_reset();
      checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid got v=%b addr=%h exp v=0 addr=0", out_valid, imem_addr); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic        rv;
      logic        hr;
      logic        rdy;
      logic [31:0] rpc;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rv  = ($urandom_range(0, 9) == 0);
         hr  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
         rpc[1:0] = 2'b00;
`endif
         cycle(rv, rpc, hr, rdy);
         checks++;
         if (out_valid !== (m_q.size() > 0) || imem_addr !== m_pc || halted !== m_halted || fault !== m_fault) begin
            errors++;
            $display("FAIL rand_state_%0d got v=%b addr=%h h=%b f=%b exp v=%b addr=%h h=%b f=%b",
                     n, out_valid, imem_addr, halted, fault, (m_q.size() > 0), m_pc, m_halted, m_fault);
         end
         if (m_q.size() > 0) begin
            checks++;
            if ({out_pc, out_instr} !== m_q[0]) begin
               errors++;
               $display("FAIL rand_head_%0d got %h exp %h", n, {out_pc, out_instr}, m_q[0]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
